// File: rtl/line_endpoint_latch.sv
`default_nettype none
// ============================================================================
// Module      : line_endpoint_latch
// Description : Frame-synchronous endpoint buffer for line_sprite. Endpoint
//               updates are clamped and staged at any time. They are presented
//               only on the frame edge (start of vertical blanking), so a drawn
//               line never tears mid-frame. A one-cycle sprite re-init pulse is
//               issued every frame edge. line_active drops after
//               TIMEOUT_FRAMES frame edges without an update.
//               Optional feature macro: LINE_LATCH_SMOOTH_EN. When it is
//               defined, reloads while showing are averaged with the
//               displayed values.
// Revision    : 1.0 - initial release
// ============================================================================
module line_endpoint_latch #(
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  input  logic [10:0] x1_in,
  input  logic [10:0] x2_in,
  input  logic [9:0]  y1_in,
  input  logic [9:0]  y2_in,
  output logic [10:0] x1_out,
  output logic [10:0] x2_out,
  output logic [9:0]  y1_out,
  output logic [9:0]  y2_out,
  output logic        line_active_out,
  output logic        line_rst_out,
  output logic        pending_out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LIMIT = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_EDGE  = 10'(V_ACTIVE);
  localparam logic [7:0]  TO_CNT  = 8'(TIMEOUT_FRAMES);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_x1_stg, r_x2_stg, w_x1_stg_nxt, w_x2_stg_nxt;
  logic [9:0]  r_y1_stg, r_y2_stg, w_y1_stg_nxt, w_y2_stg_nxt;
  logic [10:0] r_x1_out, r_x2_out, w_x1_out_nxt, w_x2_out_nxt;
  logic [9:0]  r_y1_out, r_y2_out, w_y1_out_nxt, w_y2_out_nxt;
  logic        r_pending, w_pending_nxt;
  logic        r_active, w_active_nxt;
  logic        r_line_rst, w_line_rst_nxt;
  logic [7:0]  r_frame_cnt, w_frame_cnt_nxt;

  logic        w_frame_edge;
  logic [10:0] w_x1_clamp, w_x2_clamp;
  logic [9:0]  w_y1_clamp, w_y2_clamp;
  logic [10:0] w_x1_load, w_x2_load;
  logic [9:0]  w_y1_load, w_y2_load;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;

  assign w_frame_edge = (hcount_in == 11'd0) && (vcount_in == V_EDGE);

  assign w_x1_clamp = (x1_in > X_LIMIT) ? X_LIMIT : x1_in;
  assign w_x2_clamp = (x2_in > X_LIMIT) ? X_LIMIT : x2_in;
  assign w_y1_clamp = (y1_in > Y_LIMIT) ? Y_LIMIT : y1_in;
  assign w_y2_clamp = (y2_in > Y_LIMIT) ? Y_LIMIT : y2_in;

`ifdef LINE_LATCH_SMOOTH_EN
  // Rounded mean; the widened sum cannot overflow.
  function automatic logic [10:0] avg_x(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b} + 12'd1;
    return s[11:1];
  endfunction

  function automatic logic [9:0] avg_y(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b} + 11'd1;
    return s[10:1];
  endfunction

  // While showing, blend toward the new endpoints; from idle load them directly.
  assign w_x1_load = (r_state == ST_SHOW) ? avg_x(r_x1_out, r_x1_stg) : r_x1_stg;
  assign w_x2_load = (r_state == ST_SHOW) ? avg_x(r_x2_out, r_x2_stg) : r_x2_stg;
  assign w_y1_load = (r_state == ST_SHOW) ? avg_y(r_y1_out, r_y1_stg) : r_y1_stg;
  assign w_y2_load = (r_state == ST_SHOW) ? avg_y(r_y2_out, r_y2_stg) : r_y2_stg;
`else
  assign w_x1_load = r_x1_stg;
  assign w_x2_load = r_x2_stg;
  assign w_y1_load = r_y1_stg;
  assign w_y2_load = r_y2_stg;
`endif

  assign w_cnt_inc = (r_frame_cnt == 8'hFF) ? 8'hFF : r_frame_cnt + 8'd1;
  assign w_timeout = (TIMEOUT_FRAMES != 0) && (w_cnt_inc == TO_CNT);

  // Next-state logic: capture into staging any cycle, publish on the frame edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_x1_stg_nxt    = r_x1_stg;
    w_x2_stg_nxt    = r_x2_stg;
    w_y1_stg_nxt    = r_y1_stg;
    w_y2_stg_nxt    = r_y2_stg;
    w_x1_out_nxt    = r_x1_out;
    w_x2_out_nxt    = r_x2_out;
    w_y1_out_nxt    = r_y1_out;
    w_y2_out_nxt    = r_y2_out;
    w_pending_nxt   = r_pending;
    w_active_nxt    = r_active;
    w_frame_cnt_nxt = r_frame_cnt;
    w_line_rst_nxt  = 1'b0;

    if (w_frame_edge) begin
      w_line_rst_nxt = 1'b1;
      if (r_pending) begin
        // Previously staged data is published; a coincident update re-arms below.
        w_x1_out_nxt    = w_x1_load;
        w_x2_out_nxt    = w_x2_load;
        w_y1_out_nxt    = w_y1_load;
        w_y2_out_nxt    = w_y2_load;
        w_active_nxt    = 1'b1;
        w_state_nxt     = ST_SHOW;
        w_frame_cnt_nxt = 8'd0;
        w_pending_nxt   = 1'b0;
      end else begin
        w_frame_cnt_nxt = w_cnt_inc;
        if (w_timeout) begin
          w_active_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
    end

    if (valid_in) begin
      w_x1_stg_nxt  = w_x1_clamp;
      w_x2_stg_nxt  = w_x2_clamp;
      w_y1_stg_nxt  = w_y1_clamp;
      w_y2_stg_nxt  = w_y2_clamp;
      w_pending_nxt = 1'b1;
    end
  end

  // State and datapath registers; reset discards any staged update.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_x1_stg    <= '0;
      r_x2_stg    <= '0;
      r_y1_stg    <= '0;
      r_y2_stg    <= '0;
      r_x1_out    <= '0;
      r_x2_out    <= '0;
      r_y1_out    <= '0;
      r_y2_out    <= '0;
      r_pending   <= 1'b0;
      r_active    <= 1'b0;
      r_line_rst  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x1_stg    <= w_x1_stg_nxt;
      r_x2_stg    <= w_x2_stg_nxt;
      r_y1_stg    <= w_y1_stg_nxt;
      r_y2_stg    <= w_y2_stg_nxt;
      r_x1_out    <= w_x1_out_nxt;
      r_x2_out    <= w_x2_out_nxt;
      r_y1_out    <= w_y1_out_nxt;
      r_y2_out    <= w_y2_out_nxt;
      r_pending   <= w_pending_nxt;
      r_active    <= w_active_nxt;
      r_line_rst  <= w_line_rst_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  assign x1_out          = r_x1_out;
  assign x2_out          = r_x2_out;
  assign y1_out          = r_y1_out;
  assign y2_out          = r_y2_out;
  assign line_active_out = r_active;
  assign line_rst_out    = r_line_rst;
  assign pending_out     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_line_endpoint_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_endpoint_latch
// Description : Directed bench for line_endpoint_latch with a frame-level
//               reference model checked every cycle, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_endpoint_latch;

  localparam int H_A = 1280;
  localparam int V_A = 720;
  localparam int TO  = 3;
`ifdef LINE_LATCH_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd50;
  logic        valid = 1'b0;
  logic [10:0] x1 = '0, x2 = '0;
  logic [9:0]  y1 = '0, y2 = '0;
  logic [10:0] x1_o, x2_o;
  logic [9:0]  y1_o, y2_o;
  logic        act_o, lrst_o, pend_o;

  int n_checks = 0;
  int n_errors = 0;

  line_endpoint_latch #(
    .H_ACTIVE(H_A), .V_ACTIVE(V_A), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .valid_in(valid), .x1_in(x1), .x2_in(x2), .y1_in(y1), .y2_in(y2),
    .x1_out(x1_o), .x2_out(x2_o), .y1_out(y1_o), .y2_out(y2_o),
    .line_active_out(act_o), .line_rst_out(lrst_o), .pending_out(pend_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: coordinate order is x1, y1, x2, y2.
  int m_shown[4];
  int m_stage[4];
  int m_lim[4] = '{H_A - 1, V_A - 1, H_A - 1, V_A - 1};
  int m_pend, m_active, m_cnt, m_rst;
  int in_v[4];
  bit fe;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_shown[i] = 0; m_stage[i] = 0; end
      m_pend = 0; m_active = 0; m_cnt = 0; m_rst = 0;
    end else begin
      fe = (hcount == 0) && (vcount == V_A);
      m_rst = fe ? 1 : 0;
      if (fe) begin
        if (m_pend != 0) begin
          for (int i = 0; i < 4; i++)
            m_shown[i] = (SMOOTH && m_active != 0) ? (m_shown[i] + m_stage[i] + 1) / 2
                                                   : m_stage[i];
          m_active = 1; m_cnt = 0; m_pend = 0;
        end else begin
          m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          if (TO != 0 && m_cnt == TO) m_active = 0;
        end
      end
      if (valid) begin
        in_v[0] = int'(x1); in_v[1] = int'(y1); in_v[2] = int'(x2); in_v[3] = int'(y2);
        for (int i = 0; i < 4; i++) m_stage[i] = (in_v[i] < m_lim[i]) ? in_v[i] : m_lim[i];
        m_pend = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("x1_out", int'(x1_o), m_shown[0]);
      chk("y1_out", int'(y1_o), m_shown[1]);
      chk("x2_out", int'(x2_o), m_shown[2]);
      chk("y2_out", int'(y2_o), m_shown[3]);
      chk("line_active_out", int'(act_o), m_active);
      chk("line_rst_out", int'(lrst_o), m_rst);
      chk("pending_out", int'(pend_o), m_pend);
    end
  end

  // One clock with the given counters and optional update; valid lasts one cycle.
  task automatic cyc(input int h, input int v, input bit vld,
                     input int a, input int b, input int c, input int d);
    hcount = 11'(h); vcount = 10'(v); valid = vld;
    x1 = 11'(a); y1 = 10'(b); x2 = 11'(c); y2 = 10'(d);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(10 + i, 50, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic fedge();
    cyc(0, V_A, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic upd(input int a, input int b, input int c, input int d);
    cyc(7, 50, 1'b1, a, b, c, d);
  endtask

  task automatic coords(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, ".x1"}, int'(x1_o), a);
    chk({tag, ".y1"}, int'(y1_o), b);
    chk({tag, ".x2"}, int'(x2_o), c);
    chk({tag, ".y2"}, int'(y2_o), d);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    coords("reset", 0, 0, 0, 0);
    chk("reset.active", int'(act_o), 0);
    chk("reset.pending", int'(pend_o), 0);

    // Single update appears on the frame edge.
    upd(100, 200, 300, 250);
    chk("t1.pending_before", int'(pend_o), 1);
    idle(3);
    chk("t1.x1_before", int'(x1_o), 0);
    fedge();
    coords("t1", 100, 200, 300, 250);
    chk("t1.active", int'(act_o), 1);
    chk("t1.lrst", int'(lrst_o), 1);
    chk("t1.pending", int'(pend_o), 0);
    idle(1);
    chk("t1.lrst_drop", int'(lrst_o), 0);

    // Newest of several updates wins.
    upd(10, 20, 30, 40); idle(1);
    upd(11, 21, 31, 41); idle(1);
    upd(12, 22, 32, 42); idle(2);
    coords("t2.before", 100, 200, 300, 250);
    fedge();
`ifndef LINE_LATCH_SMOOTH_EN
    coords("t2", 12, 22, 32, 42);
`endif
    idle(2);

    // Clamping of out-of-range coordinates.
    upd(2000, 5, 7, 900); idle(2);
    fedge();
`ifndef LINE_LATCH_SMOOTH_EN
    coords("t3", 1279, 5, 7, 719);
`endif
    idle(2);

    // Timeout after TO edges without an update.
    fedge(); idle(2);
    fedge();
    chk("t4.active_edge2", int'(act_o), 1);
    idle(2);
    fedge();
    chk("t4.active_edge3", int'(act_o), 0);
    chk("t4.lrst_edge3", int'(lrst_o), 1);
    idle(2);

    // Update coincident with the frame edge.
    upd(50, 60, 70, 80); idle(2);
    cyc(0, V_A, 1'b1, 90, 91, 92, 93);
    coords("t5.first", 50, 60, 70, 80);
    chk("t5.pending_kept", int'(pend_o), 1);
    idle(3);
    fedge();
`ifndef LINE_LATCH_SMOOTH_EN
    coords("t5.second", 90, 91, 92, 93);
`endif
    chk("t5.pending_clr", int'(pend_o), 0);
    idle(2);

    // Coincident update with nothing pending counts as a no-update frame.
    cyc(0, V_A, 1'b1, 400, 300, 200, 100);
    chk("t5b.pending", int'(pend_o), 1);
    idle(2);
    fedge(); idle(2);

`ifdef LINE_LATCH_SMOOTH_EN
    // Drive to idle, then shown 100 blended with staged 201.
    fedge(); idle(1); fedge(); idle(1); fedge(); idle(1);
    chk("t6.idle", int'(act_o), 0);
    upd(100, 10, 10, 10); fedge();
    chk("t6.x1_direct", int'(x1_o), 100);
    upd(201, 10, 10, 10); fedge();
    chk("t6.x1_avg", int'(x1_o), 151);
    fedge(); idle(1); fedge(); idle(1); fedge(); idle(1);
    upd(500, 10, 10, 10); fedge();
    chk("t6.x1_after_to", int'(x1_o), 500);
    idle(2);
`endif

    // Mid-frame reset discards staged data.
    upd(333, 222, 111, 99); idle(1);
    #2 rst = 1'b1;
    #1;
    coords("rst_mid", 0, 0, 0, 0);
    chk("rst_mid.pending", int'(pend_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);
    chk("rst_mid.lrst", int'(lrst_o), 0);
    fedge();
    coords("rst_mid.edge", 0, 0, 0, 0);
    chk("rst_mid.active", int'(act_o), 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
